// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution control sequencer.
package conv_pkg;

    localparam int IMG_AW  = 16;
    localparam int KERN_AW = 6;
    localparam int RES_AW  = 11;

    // Kernel coefficient address layouts
    localparam logic KMODE_PACKED  = 1'b0;  // k*kern_cols + t
    localparam logic KMODE_ALIGNED = 1'b1;  // {k, t}

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_e;

    // Geometry captured on the start edge
    typedef struct packed {
        logic [2:0] kern_cols;
        logic [7:0] cols;
        logic [2:0] kerns;
        logic [7:0] stride;
        logic [7:0] result_cols;
        logic       kern_addr_mode;
    } conv_cfg_t;

endpackage

// File: rtl/conv_sequencer_if.sv
// Tap interface between the sequencer and the MAC datapath.
// Handshake: a tap transfers on a cycle where tap_valid && mem_ready are both
// high; while tap_valid is high and mem_ready is low, every tap field is held
// stable; tap_valid never drops until the tap has been accepted.
interface conv_sequencer_if;
    import conv_pkg::*;

    logic               mem_ready;
    logic               tap_valid;
    logic               img_rd_en;
    logic [IMG_AW-1:0]  img_addr;
    logic [KERN_AW-1:0] kern_addr;
    logic [RES_AW-1:0]  res_addr;
    logic               accum_clr;
    logic               accum_last;

    modport master (
        input  mem_ready,
        output tap_valid, img_rd_en, img_addr, kern_addr, res_addr,
        accum_clr, accum_last
    );

    modport slave (
        output mem_ready,
        input  tap_valid, img_rd_en, img_addr, kern_addr, res_addr,
        accum_clr, accum_last
    );
endinterface

// File: rtl/conv_idx_counter.sv
// Nested kernel/result/tap index counters; t is innermost, k outermost.
// Exposes next-cycle indices so the caller can register addresses from them.
module conv_idx_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [2:0] kern_cols,
    input  logic [7:0] result_cols,
    input  logic [2:0] kerns,
    output logic [2:0] k_nxt,
    output logic [7:0] r_nxt,
    output logic [2:0] t_nxt,
    output logic       final_tap
);
    logic [2:0] k_q, k_d;
    logic [7:0] r_q, r_d;
    logic [2:0] t_q, t_d;
    logic       t_last, r_last, k_last;

    // Wrap detection and next-index computation
    always_comb begin
        t_last    = (t_q == kern_cols - 3'd1);
        r_last    = (r_q == result_cols - 8'd1);
        k_last    = (k_q == kerns - 3'd1);
        final_tap = t_last && r_last && k_last;
        k_d = k_q;
        r_d = r_q;
        t_d = t_q;
        if (clr) begin
            k_d = '0;
            r_d = '0;
            t_d = '0;
        end else if (en) begin
            if (t_last) begin
                t_d = '0;
                if (r_last) begin
                    r_d = '0;
                    k_d = k_last ? 3'd0 : k_q + 3'd1;
                end else begin
                    r_d = r_q + 8'd1;
                end
            end else begin
                t_d = t_q + 3'd1;
            end
        end
    end

    // Index registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q <= '0;
            r_q <= '0;
            t_q <= '0;
        end else begin
            k_q <= k_d;
            r_q <= r_d;
            t_q <= t_d;
        end
    end

    assign k_nxt = k_d;
    assign r_nxt = r_d;
    assign t_nxt = t_d;
endmodule

// File: rtl/conv_sequencer.sv
// Convolution control sequencer: walks kernel x result x tap indices after a
// start edge and issues registered tap addresses and accumulator flags.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             soft_reset,
    input  logic [2:0]       kern_cols,
    input  logic [7:0]       cols,
    input  logic [2:0]       kerns,
    input  logic [7:0]       stride,
    input  logic [7:0]       result_cols,
    input  logic             kern_addr_mode,
    conv_sequencer_if.master mem,
    output logic             busy,
    output logic             done,
    output conv_state_e      dbg_state
);
    conv_state_e        state_q, state_d;
    conv_cfg_t          cfg_q, cfg_d;
    logic [3:0]         flush_q, flush_d;
    logic               start_q;
    logic               armed_q, armed_d;
    logic               start_rise;
    logic               cnt_clr, cnt_en, final_tap;
    logic [2:0]         k_nxt, t_nxt;
    logic [7:0]         r_nxt;

    logic               tap_valid_q, tap_valid_d;
    logic               img_rd_en_q, img_rd_en_d;
    logic [IMG_AW-1:0]  img_addr_q, img_addr_d;
    logic [KERN_AW-1:0] kern_addr_q, kern_addr_d;
    logic [RES_AW-1:0]  res_addr_q, res_addr_d;
    logic               accum_clr_q, accum_clr_d;
    logic               accum_last_q, accum_last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // A start level already high when reset releases is not a fresh request,
    // so edges only count once start has been seen low.
    assign armed_d    = armed_q | ~start;
    assign start_rise = start & ~start_q & armed_q;

    conv_idx_counter u_idx (
        .clk         (clk),
        .reset       (reset),
        .clr         (cnt_clr),
        .en          (cnt_en),
        .kern_cols   (cfg_q.kern_cols),
        .result_cols (cfg_q.result_cols),
        .kerns       (cfg_q.kerns),
        .k_nxt       (k_nxt),
        .r_nxt       (r_nxt),
        .t_nxt       (t_nxt),
        .final_tap   (final_tap)
    );

    // FSM next state, config capture and next-cycle status flags
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        flush_d     = flush_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        tap_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        if (soft_reset) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
            flush_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_rise) begin
                        cfg_d   = '{kern_cols: kern_cols, cols: cols, kerns: kerns,
                                    stride: stride, result_cols: result_cols,
                                    kern_addr_mode: kern_addr_mode};
                        cnt_clr = 1'b1;
                        if (kerns == '0 || result_cols == '0 || kern_cols == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = ST_RUN;
                            tap_valid_d = 1'b1;
                            busy_d      = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    tap_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    if (mem.mem_ready) begin
                        cnt_en = 1'b1;
                        if (final_tap) begin
                            state_d     = ST_FLUSH;
                            tap_valid_d = 1'b0;
                            flush_d     = '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    busy_d = 1'b1;
                    if (flush_q == 4'(PIPE_DEPTH - 1)) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        flush_d = flush_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    done_d = 1'b1;
                    if (!start) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Tap fields for the next cycle, computed from the next indices; zero when idle
    always_comb begin
        img_addr_d   = '0;
        kern_addr_d  = '0;
        res_addr_d   = '0;
        img_rd_en_d  = 1'b0;
        accum_clr_d  = 1'b0;
        accum_last_d = 1'b0;
        if (tap_valid_d) begin
            img_addr_d  = IMG_AW'(r_nxt) * IMG_AW'(cfg_d.stride) + IMG_AW'(t_nxt);
            kern_addr_d = (cfg_d.kern_addr_mode == KMODE_ALIGNED) ? {k_nxt, t_nxt} :
                          KERN_AW'(k_nxt) * KERN_AW'(cfg_d.kern_cols) + KERN_AW'(t_nxt);
            res_addr_d  = RES_AW'(k_nxt) * RES_AW'(cfg_d.result_cols) + RES_AW'(r_nxt);
            // Out-of-range columns are padding: tap still issued, no read
            img_rd_en_d  = (img_addr_d < IMG_AW'(cfg_d.cols));
            accum_clr_d  = (t_nxt == 3'd0);
            accum_last_d = (t_nxt == cfg_d.kern_cols - 3'd1);
        end
    end

    // State, config shadow and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cfg_q        <= '0;
            flush_q      <= '0;
            start_q      <= 1'b0;
            armed_q      <= 1'b0;
            tap_valid_q  <= 1'b0;
            img_rd_en_q  <= 1'b0;
            img_addr_q   <= '0;
            kern_addr_q  <= '0;
            res_addr_q   <= '0;
            accum_clr_q  <= 1'b0;
            accum_last_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            flush_q      <= flush_d;
            start_q      <= start;
            armed_q      <= armed_d;
            tap_valid_q  <= tap_valid_d;
            img_rd_en_q  <= img_rd_en_d;
            img_addr_q   <= img_addr_d;
            kern_addr_q  <= kern_addr_d;
            res_addr_q   <= res_addr_d;
            accum_clr_q  <= accum_clr_d;
            accum_last_q <= accum_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign mem.tap_valid  = tap_valid_q;
    assign mem.img_rd_en  = img_rd_en_q;
    assign mem.img_addr   = img_addr_q;
    assign mem.kern_addr  = kern_addr_q;
    assign mem.res_addr   = res_addr_q;
    assign mem.accum_clr  = accum_clr_q;
    assign mem.accum_last = accum_last_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: basic walk, padding/aligned mode, stall,
// zero geometry, soft abort and asynchronous reset during flush.
module tb_conv_sequencer;
    import conv_pkg::*;

    typedef struct packed {
        logic [15:0] img;
        logic        rd;
        logic [5:0]  kern;
        logic [10:0] res;
        logic        clr;
        logic        last;
    } tap_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        soft_reset;
    logic [2:0]  kern_cols;
    logic [7:0]  cols;
    logic [2:0]  kerns;
    logic [7:0]  stride;
    logic [7:0]  result_cols;
    logic        kern_addr_mode;
    logic        busy;
    logic        done;
    conv_state_e dbg_state;

    int checks   = 0;
    int failures = 0;
    tap_t exp_q[$];

    conv_sequencer_if mem_if ();

    conv_sequencer #(.PIPE_DEPTH(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .soft_reset     (soft_reset),
        .kern_cols      (kern_cols),
        .cols           (cols),
        .kerns          (kerns),
        .stride         (stride),
        .result_cols    (result_cols),
        .kern_addr_mode (kern_addr_mode),
        .mem            (mem_if.master),
        .busy           (busy),
        .done           (done),
        .dbg_state      (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input int img, input bit rd, input int kern,
                                 input int res, input bit clr, input bit last);
        tap_t e;
        e.img  = 16'(img);
        e.rd   = rd;
        e.kern = 6'(kern);
        e.res  = 11'(res);
        e.clr  = clr;
        e.last = last;
        exp_q.push_back(e);
    endfunction

    // kerns=1 kern_cols=3 result_cols=2 stride=1 cols=8 packed
    task automatic setup_basic();
        kerns = 3'd1; kern_cols = 3'd3; result_cols = 8'd2; stride = 8'd1;
        cols = 8'd8; kern_addr_mode = KMODE_PACKED;
        exp_q.delete();
        push(0, 1, 0, 0, 1, 0); push(1, 1, 1, 0, 0, 0); push(2, 1, 2, 0, 0, 1);
        push(1, 1, 0, 1, 1, 0); push(2, 1, 1, 1, 0, 0); push(3, 1, 2, 1, 0, 1);
    endtask

    // kerns=2 kern_cols=2 result_cols=2 stride=2 cols=3 aligned
    task automatic setup_pad();
        kerns = 3'd2; kern_cols = 3'd2; result_cols = 8'd2; stride = 8'd2;
        cols = 8'd3; kern_addr_mode = KMODE_ALIGNED;
        exp_q.delete();
        push(0, 1, 0, 0, 1, 0); push(1, 1, 1, 0, 0, 1);
        push(2, 1, 0, 1, 1, 0); push(3, 0, 1, 1, 0, 1);
        push(0, 1, 8, 2, 1, 0); push(1, 1, 9, 2, 0, 1);
        push(2, 1, 8, 3, 1, 0); push(3, 0, 9, 3, 0, 1);
    endtask

    task automatic check_tap(input string tag, input tap_t e);
        chk({tag, "_valid"}, 32'(mem_if.tap_valid), 32'(1));
        chk({tag, "_img"},   32'(mem_if.img_addr),  32'(e.img));
        chk({tag, "_rd"},    32'(mem_if.img_rd_en), 32'(e.rd));
        chk({tag, "_kern"},  32'(mem_if.kern_addr), 32'(e.kern));
        chk({tag, "_res"},   32'(mem_if.res_addr),  32'(e.res));
        chk({tag, "_clr"},   32'(mem_if.accum_clr), 32'(e.clr));
        chk({tag, "_last"},  32'(mem_if.accum_last), 32'(e.last));
        chk({tag, "_busy"},  32'(busy), 32'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(mem_if.tap_valid), 32'(0));
        chk({tag, "_rd"},    32'(mem_if.img_rd_en), 32'(0));
        chk({tag, "_img"},   32'(mem_if.img_addr),  32'(0));
        chk({tag, "_kern"},  32'(mem_if.kern_addr), 32'(0));
        chk({tag, "_res"},   32'(mem_if.res_addr),  32'(0));
        chk({tag, "_clr"},   32'(mem_if.accum_clr), 32'(0));
        chk({tag, "_last"},  32'(mem_if.accum_last), 32'(0));
        chk({tag, "_busy"},  32'(busy), 32'(0));
        chk({tag, "_done"},  32'(done), 32'(0));
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Consume every queued tap (first tap already on the outputs), then wait for done
    task automatic run_seq(input string tag, input int stall_at, input int stall_len,
                           input int exp_total);
        int   total = 0;
        int   waited = 0;
        int   n;
        tap_t e;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            if (i == stall_at) begin
                mem_if.mem_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check_tap($sformatf("%s_stall%0d", tag, s), e);
                    step();
                    total++;
                end
                mem_if.mem_ready = 1'b1;
            end
            check_tap($sformatf("%s_tap%0d", tag, i), e);
            step();
            total++;
        end
        chk({tag, "_flush_busy"},  32'(busy), 32'(1));
        chk({tag, "_flush_valid"}, 32'(mem_if.tap_valid), 32'(0));
        while (!done && waited < 64) begin
            step();
            waited++;
            total++;
        end
        chk({tag, "_done"},  32'(done), 32'(1));
        chk({tag, "_total"}, 32'(total), 32'(exp_total));
    endtask

    // Drop start and confirm the return to IDLE
    task automatic release_start(input string tag);
        start = 1'b0;
        step();
        chk({tag, "_done_clr"}, 32'(done), 32'(0));
        chk({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        tap_t e;
        reset = 1'b0; start = 1'b0; soft_reset = 1'b0;
        kern_cols = '0; cols = '0; kerns = '0; stride = '0; result_cols = '0;
        kern_addr_mode = 1'b0;
        mem_if.mem_ready = 1'b1;

        // Reset state
        step(); step();
        check_idle_outputs("reset");
        reset = 1'b1;
        step(); step();

        // Basic run: 6 taps, done 4 cycles after the last accepted tap
        setup_basic();
        start = 1'b1;
        step();
        run_seq("basic", -1, 0, 9);
        release_start("basic");

        // Padding and aligned kernel addressing
        setup_pad();
        start = 1'b1;
        step();
        run_seq("pad", -1, 0, 11);
        release_start("pad");

        // Stall of 3 cycles on tap 2 delays done by exactly 3
        setup_basic();
        start = 1'b1;
        step();
        run_seq("stall", 2, 3, 12);
        release_start("stall");

        // Zero geometry goes straight to DONE without a tap
        kerns = 3'd1; kern_cols = 3'd3; result_cols = 8'd0;
        start = 1'b1;
        step();
        chk("zero_valid", 32'(mem_if.tap_valid), 32'(0));
        chk("zero_busy",  32'(busy), 32'(0));
        chk("zero_done",  32'(done), 32'(1));
        chk("zero_state", 32'(dbg_state), 32'(ST_DONE));
        step();
        chk("zero_done_hold", 32'(done), 32'(1));
        release_start("zero");

        // Soft abort at tap 4, then a clean rerun
        setup_basic();
        start = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            check_tap($sformatf("abort_tap%0d", i), e);
            step();
        end
        chk("abort_tap4_img", 32'(mem_if.img_addr), 32'(2));
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        check_idle_outputs("abort");
        step();
        chk("abort_no_retrigger", 32'(mem_if.tap_valid), 32'(0));
        start = 1'b0;
        step();
        setup_basic();
        start = 1'b1;
        step();
        run_seq("rerun", -1, 0, 9);
        release_start("rerun");

        // Async reset in FLUSH with start held high
        setup_basic();
        start = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            check_tap($sformatf("areset_tap%0d", i), e);
            step();
        end
        chk("areset_in_flush", 32'(dbg_state), 32'(ST_FLUSH));
        #1;
        reset = 1'b0;
        #1;
        check_idle_outputs("areset_now");
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("areset_held%0d_valid", i), 32'(mem_if.tap_valid), 32'(0));
            chk($sformatf("areset_held%0d_busy", i), 32'(busy), 32'(0));
        end
        start = 1'b0;
        step();
        setup_basic();
        start = 1'b1;
        step();
        run_seq("after_rst", -1, 0, 9);
        release_start("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Control sequencer for the convolution engine. It sits directly downstream of the control/status register block: it consumes `start`, `soft_reset` and the geometry fields, walks kernel × result × tap indices, and drives image/kernel memory reads and accumulator control to the MAC datapath. It returns `done` to the status register. `shift`, `mask` and `en_max_pool` bypass this block and go to the datapath.

## Interface
- `PIPE_DEPTH`, 3: cycles from an accepted tap to the final accumulator update. It sets the FLUSH length. Legal range 1–15.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: level from the control register. The block acts on its rising edge.
- `soft_reset` in 1: synchronous abort to IDLE, active-high.
- `kern_cols` in 3: taps per kernel.
- `cols` in 8: valid image columns.
- `kerns` in 3: kernel count.
- `stride` in 8: image step between results.
- `result_cols` in 8: results per kernel.
- `kern_addr_mode` in 1: 0 = packed (`k*kern_cols+t`), 1 = aligned (`{k,t}`).
- `mem_ready` in 1: datapath accepts the current tap this cycle.
- `tap_valid` out 1: current tap outputs are valid.
- `img_rd_en` out 1: image read enable. Equals `tap_valid` and the address is in range.
- `img_addr` out 16: `r*stride + t`.
- `kern_addr` out 6: kernel coefficient address.
- `res_addr` out 11: `k*result_cols + r`.
- `accum_clr` out 1: first tap of a result (`t==0`).
- `accum_last` out 1: last tap of a result (`t==kern_cols-1`).
- `busy` out 1: the FSM is in RUN or FLUSH.
- `done` out 1: the FSM is in DONE, to status bit 0.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - On a `start` rising edge, latch all config inputs into shadow registers. Later changes to the inputs are ignored until the next start.
  - Clear k, r, t to 0.
  - If any of the latched `kerns`, `result_cols` or `kern_cols` is zero, go to DONE directly. No tap is issued.
  - Otherwise go to RUN.
- RUN:
  - `tap_valid`=1.
  - On `mem_ready`=1, advance the nested counters: t is innermost, then r, then k. t wraps at `kern_cols-1`, r wraps at `result_cols-1`.
  - When the final tap (k=kerns-1, r=result_cols-1, t=kern_cols-1) is accepted, go to FLUSH.
  - On `mem_ready`=0, hold all outputs stable.
- Padding: a tap with `r*stride+t >= cols` keeps `tap_valid`=1 and `img_rd_en`=0. The datapath then adds zero. The accumulator flags are still issued for it.
- FLUSH: count `PIPE_DEPTH` cycles, then go to DONE.
- DONE:
  - `done`=1, held until `start` is low. Then go to IDLE.
  - A `start` that is still high does not retrigger.
- Rising edges of `start` outside IDLE are ignored. The edge detector register still updates.
- `soft_reset`=1 in any state:
  - Next cycle: IDLE, counters cleared, all outputs 0, `done` cleared.
  - While it is held, `start` edges are ignored.
- Arithmetic:
  - `img_addr` is a 16-bit product plus tap, with no overflow (255·255+7 < 2^16).
  - `kern_addr` is 6 bits.
  - `res_addr` is 11 bits (6·255+254 < 2^11).
  - `stride`=0 is legal: every result reads taps 0..kern_cols-1.

## Timing
- Reset values: state IDLE. `tap_valid`, `img_rd_en`, `accum_clr`, `accum_last`, `busy` and `done` are all 0. Addresses are 0. The start-edge register is 0.
- All outputs are registered.
- The start edge is sampled at cycle N. The first tap is valid at N+1 with `busy`=1.
- Throughput: one tap per cycle while `mem_ready`=1.
- Total RUN cycles = `kerns·result_cols·kern_cols` plus the stall cycles.
- `done` rises `PIPE_DEPTH+1` cycles after the cycle in which the last tap is accepted.
- For the zero-config case, `done` rises at N+1.
- Async `reset` mid-run forces reset values immediately. No tap is issued after release until a new start edge.

## Structure
- Package `conv_pkg` holds:
  - the state enum (IDLE/RUN/FLUSH/DONE, 2-bit);
  - width constants `IMG_AW`=16, `KERN_AW`=6, `RES_AW`=11;
  - the `kern_addr_mode` encodings.
- Sub-module `conv_idx_counter`: the three nested wrap counters with enable, clear and last-index flags. It keeps the RUN logic and address generation separate from the FSM.

## Test plan
- Basic run: kerns=1, kern_cols=3, result_cols=2, stride=1, cols=8, `mem_ready`=1 → `img_addr` 0,1,2,1,2,3. `accum_clr` on taps 0 and 3, `accum_last` on taps 2 and 5. `done` 4 cycles after the 6th tap.
- Padding and mode: kerns=2, kern_cols=2, result_cols=2, stride=2, cols=3, mode=1.
  - `img_addr` 0,1,2,3 per kernel, with `img_rd_en`=0 on `img_addr` 3.
  - `kern_addr` 0,1,0,1,8,9,8,9.
  - `res_addr` 0,0,1,1,2,2,3,3.
- Stall: `mem_ready` low for 3 cycles at tap 2 → outputs frozen for those cycles, then the sequence resumes unchanged and `done` is delayed by exactly 3.
- Zero config: result_cols=0, start 0→1 → no `tap_valid`, `done`=1 next cycle. `done` clears one cycle after start=0.
- Abort: `soft_reset` pulse at tap 4 → IDLE next cycle, `done`=0. A new start edge runs the full sequence from tap 0.
- Async reset asserted mid-FLUSH, then released → all outputs 0 immediately. With `start` held high there is no restart until start goes 0→1.
